// File: rtl/spu_gbuf_resp_pkg.sv
// Shared SPU global-buffer types: host arbiter FSM states, legal read-latency range
// and the saturating stall-counter helper.
package spu_gbuf_resp_pkg;

   typedef enum logic [0:0] {
      H_IDLE    = 1'b0,
      H_RD_WAIT = 1'b1
   } host_state_e;

   localparam int RLAT_MIN = 1;
   localparam int RLAT_MAX = 4;
   localparam int STALL_W  = 16;

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/spu_gbuf_resp_if.sv
// SPU/host access bundle for the global buffer; master drives requests, slave is the buffer.
// SPU side has no backpressure; host side is req/gnt with a separate rvalid return.
interface spu_gbuf_resp_if
   import spu_gbuf_resp_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                  sm_gbuf_ren;
   logic [ADDR_WIDTH-1:0] sm_gbuf_raddr;
   logic [DATA_WIDTH-1:0] sm_gbuf_rdata;
   logic                  sm_gbuf_wen;
   logic [ADDR_WIDTH-1:0] sm_gbuf_waddr;
   logic [DATA_WIDTH-1:0] sm_gbuf_wdata;
   logic                  host_req;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_wdata;
   logic                  host_gnt;
   logic                  host_rvalid;
   logic [DATA_WIDTH-1:0] host_rdata;
   logic [STALL_W-1:0]    host_stall_cnt;

   modport master (
      output sm_gbuf_ren, sm_gbuf_raddr, sm_gbuf_wen, sm_gbuf_waddr, sm_gbuf_wdata,
      output host_req, host_we, host_addr, host_wdata,
      input  sm_gbuf_rdata, host_gnt, host_rvalid, host_rdata, host_stall_cnt
   );

   modport slave (
      input  sm_gbuf_ren, sm_gbuf_raddr, sm_gbuf_wen, sm_gbuf_waddr, sm_gbuf_wdata,
      input  host_req, host_we, host_addr, host_wdata,
      output sm_gbuf_rdata, host_gnt, host_rvalid, host_rdata, host_stall_cnt
   );

endinterface

// File: rtl/spu_gbuf_ram.sv
// 1R1W word array, write-first on address collision, one-cycle registered read.
// No backpressure; kept standalone so an SRAM macro can replace it.
module spu_gbuf_ram #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  core_clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge core_clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      // Same-cycle collision forwards the incoming write data
      if (re) begin
         rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
      end
   end

endmodule

// File: rtl/spu_gbuf_resp.sv
// SPU global buffer with host (DMA) side port; SPU has absolute priority, host waits via req/gnt.
// Reads return after RLATENCY cycles; SPU is never stalled, host read blocks until its data returns.
module spu_gbuf_resp
   import spu_gbuf_resp_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int RLATENCY   = 1
) (
   input  logic            core_clk,
   input  logic            rst_n,
   spu_gbuf_resp_if.slave  bus
);

   if (RLATENCY < RLAT_MIN || RLATENCY > RLAT_MAX) begin : g_bad_rlat
      $error("spu_gbuf_resp: RLATENCY outside legal range");
   end

   host_state_e           state_q;
   logic                  host_wr_gnt;
   logic                  host_rd_gnt;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  ram_re;
   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [RLATENCY-1:0]   vld_q;
   logic [RLATENCY-1:0]   own_q;
   logic [DATA_WIDTH-1:0] last_dat;
   logic                  spu_done;
   logic                  host_done;
   logic [DATA_WIDTH-1:0] spu_hold_q;
   logic [DATA_WIDTH-1:0] host_hold_q;
   logic [STALL_W-1:0]    stall_q;

   // Grants are combinational so a granted host write lands in the same cycle;
   // gating with rst_n keeps the array untouched by the host while in reset.
   assign host_wr_gnt = rst_n & bus.host_req & bus.host_we & ~bus.sm_gbuf_wen;
   assign host_rd_gnt = rst_n & bus.host_req & ~bus.host_we & ~bus.sm_gbuf_ren
                        & (state_q == H_IDLE);
   assign bus.host_gnt = host_wr_gnt | host_rd_gnt;

   assign ram_we    = bus.sm_gbuf_wen | host_wr_gnt;
   assign ram_waddr = bus.sm_gbuf_wen ? bus.sm_gbuf_waddr : bus.host_addr;
   assign ram_wdata = bus.sm_gbuf_wen ? bus.sm_gbuf_wdata : bus.host_wdata;
   assign ram_re    = bus.sm_gbuf_ren | host_rd_gnt;
   assign ram_raddr = bus.sm_gbuf_ren ? bus.sm_gbuf_raddr : bus.host_addr;

   spu_gbuf_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .core_clk (core_clk),
      .we       (ram_we),
      .waddr    (ram_waddr),
      .wdata    (ram_wdata),
      .re       (ram_re),
      .raddr    (ram_raddr),
      .rdata    (ram_rdata)
   );

   // Stage 0 valid/owner aligns with the RAM output register; own=1 marks a host read
   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         own_q <= '0;
      end else begin
         vld_q[0] <= ram_re;
         own_q[0] <= host_rd_gnt;
         for (int k = 1; k < RLATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            own_q[k] <= own_q[k-1];
         end
      end
   end

   if (RLATENCY == 1) begin : g_no_dly
      assign last_dat = ram_rdata;
   end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly_q [RLATENCY-1];
      always_ff @(posedge core_clk) begin
         dly_q[0] <= ram_rdata;
         for (int k = 1; k < RLATENCY - 1; k++) begin
            dly_q[k] <= dly_q[k-1];
         end
      end
      assign last_dat = dly_q[RLATENCY-2];
   end

   assign spu_done  = vld_q[RLATENCY-1] & ~own_q[RLATENCY-1];
   assign host_done = vld_q[RLATENCY-1] &  own_q[RLATENCY-1];

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         spu_hold_q  <= '0;
         host_hold_q <= '0;
      end else begin
         if (spu_done)  spu_hold_q  <= last_dat;
         if (host_done) host_hold_q <= last_dat;
      end
   end

   assign bus.sm_gbuf_rdata = spu_done  ? last_dat : spu_hold_q;
   assign bus.host_rvalid   = host_done;
   assign bus.host_rdata    = host_done ? last_dat : host_hold_q;

   // One host read outstanding at a time; writes complete in the grant cycle
   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= H_IDLE;
      end else begin
         case (state_q)
            H_IDLE:    if (host_rd_gnt) state_q <= H_RD_WAIT;
            H_RD_WAIT: if (host_done)   state_q <= H_IDLE;
            default:   state_q <= H_IDLE;
         endcase
      end
   end

   always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (bus.host_req && !bus.host_gnt) begin
         stall_q <= sat_inc(stall_q);
      end
   end

   assign bus.host_stall_cnt = stall_q;

endmodule

// File: tb/tb_spu_gbuf_resp.sv
// Directed bench for spu_gbuf_resp: one instance at RLATENCY=1, one at RLATENCY=3,
// sharing clock and reset.
module tb_spu_gbuf_resp;

   logic core_clk;
   logic rst_n;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   spu_gbuf_resp_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if1 ();
   spu_gbuf_resp_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) if3 ();

   spu_gbuf_resp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RLATENCY(1)) dut1 (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .bus      (if1.slave)
   );

   spu_gbuf_resp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RLATENCY(3)) dut3 (
      .core_clk (core_clk),
      .rst_n    (rst_n),
      .bus      (if3.slave)
   );

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge core_clk);
      #1;
   endtask

   task automatic idle_all();
      if1.sm_gbuf_ren = 0; if1.sm_gbuf_raddr = '0; if1.sm_gbuf_wen = 0;
      if1.sm_gbuf_waddr = '0; if1.sm_gbuf_wdata = '0; if1.host_req = 0;
      if1.host_we = 0; if1.host_addr = '0; if1.host_wdata = '0;
      if3.sm_gbuf_ren = 0; if3.sm_gbuf_raddr = '0; if3.sm_gbuf_wen = 0;
      if3.sm_gbuf_waddr = '0; if3.sm_gbuf_wdata = '0; if3.host_req = 0;
      if3.host_we = 0; if3.host_addr = '0; if3.host_wdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_all();
      if1.host_req = 1; if1.host_we = 1; if1.host_addr = 12'h7FF; if1.host_wdata = 32'h1;
      tick(2);
      #1;
      vec_cnt++; if (if1.sm_gbuf_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_sm_rdata1: got %h want 0", if1.sm_gbuf_rdata); end
      vec_cnt++; if (if1.host_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_host_rdata1: got %h want 0", if1.host_rdata); end
      vec_cnt++; if (if1.host_gnt !== 1'b0) begin err_cnt++; $display("FAIL rst_gnt1: got %b want 0", if1.host_gnt); end
      vec_cnt++; if (if1.host_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_rvalid1: got %b want 0", if1.host_rvalid); end
      vec_cnt++; if (if1.host_stall_cnt !== 16'h0) begin err_cnt++; $display("FAIL rst_stall1: got %h want 0", if1.host_stall_cnt); end
      vec_cnt++; if (if3.sm_gbuf_rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_sm_rdata3: got %h want 0", if3.sm_gbuf_rdata); end
      vec_cnt++; if (if3.host_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_rvalid3: got %b want 0", if3.host_rvalid); end
      if1.host_req = 0; if1.host_we = 0;
      tick(1);
      rst_n = 1;
   endtask

   task automatic test_spu_rw();
      if1.sm_gbuf_wen = 1; if1.sm_gbuf_waddr = 12'h010; if1.sm_gbuf_wdata = 32'hDEADBEEF;
      tick(1);
      if1.sm_gbuf_wen = 0; if1.sm_gbuf_ren = 1; if1.sm_gbuf_raddr = 12'h010;
      tick(1);
      if1.sm_gbuf_ren = 0;
      #1;
      vec_cnt++; if (if1.sm_gbuf_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL spu_rw: got %h want deadbeef", if1.sm_gbuf_rdata); end
      vec_cnt++; if (if1.host_rvalid !== 1'b0) begin err_cnt++; $display("FAIL spu_rw_no_hvld: got %b want 0", if1.host_rvalid); end
      tick(1);
      vec_cnt++; if (if1.sm_gbuf_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL spu_rw_hold: got %h want deadbeef", if1.sm_gbuf_rdata); end
   endtask

   task automatic test_same_cycle();
      if1.sm_gbuf_wen = 1; if1.sm_gbuf_waddr = 12'h020; if1.sm_gbuf_wdata = 32'h12345678;
      if1.sm_gbuf_ren = 1; if1.sm_gbuf_raddr = 12'h020;
      if3.sm_gbuf_wen = 1; if3.sm_gbuf_waddr = 12'h020; if3.sm_gbuf_wdata = 32'h12345678;
      if3.sm_gbuf_ren = 1; if3.sm_gbuf_raddr = 12'h020;
      tick(1);
      if1.sm_gbuf_wen = 0; if1.sm_gbuf_ren = 0;
      if3.sm_gbuf_wen = 0; if3.sm_gbuf_ren = 0;
      #1;
      vec_cnt++; if (if1.sm_gbuf_rdata !== 32'h12345678) begin err_cnt++; $display("FAIL wfirst_l1: got %h want 12345678", if1.sm_gbuf_rdata); end
      vec_cnt++; if (if3.sm_gbuf_rdata !== 32'h0) begin err_cnt++; $display("FAIL wfirst_l3_early1: got %h want 0", if3.sm_gbuf_rdata); end
      tick(1);
      vec_cnt++; if (if3.sm_gbuf_rdata !== 32'h0) begin err_cnt++; $display("FAIL wfirst_l3_early2: got %h want 0", if3.sm_gbuf_rdata); end
      tick(1);
      vec_cnt++; if (if3.sm_gbuf_rdata !== 32'h12345678) begin err_cnt++; $display("FAIL wfirst_l3: got %h want 12345678", if3.sm_gbuf_rdata); end
      vec_cnt++; if (if3.host_rvalid !== 1'b0) begin err_cnt++; $display("FAIL wfirst_l3_no_hvld: got %b want 0", if3.host_rvalid); end
   endtask

   task automatic test_host_write_stall();
      if1.sm_gbuf_wen = 1; if1.sm_gbuf_waddr = 12'h100; if1.sm_gbuf_wdata = 32'h11111111;
      if1.host_req = 1; if1.host_we = 1; if1.host_addr = 12'h030; if1.host_wdata = 32'hA5A5A5A5;
      for (int c = 0; c < 3; c++) begin
         #1;
         vec_cnt++; if (if1.host_gnt !== 1'b0) begin err_cnt++; $display("FAIL hwr_blocked[%0d]: got %b want 0", c, if1.host_gnt); end
         tick(1);
      end
      if1.sm_gbuf_wen = 0;
      #1;
      vec_cnt++; if (if1.host_gnt !== 1'b1) begin err_cnt++; $display("FAIL hwr_gnt: got %b want 1", if1.host_gnt); end
      tick(1);
      if1.host_req = 0; if1.host_we = 0;
      #1;
      vec_cnt++; if (if1.host_stall_cnt !== 16'd3) begin err_cnt++; $display("FAIL hwr_stall: got %0d want 3", if1.host_stall_cnt); end
      if1.sm_gbuf_ren = 1; if1.sm_gbuf_raddr = 12'h030;
      tick(1);
      if1.sm_gbuf_ren = 0;
      #1;
      vec_cnt++; if (if1.sm_gbuf_rdata !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL hwr_readback: got %h want a5a5a5a5", if1.sm_gbuf_rdata); end
   endtask

   task automatic test_host_read();
      if3.host_req = 1; if3.host_we = 1; if3.host_addr = 12'h030; if3.host_wdata = 32'hA5A5A5A5;
      #1;
      vec_cnt++; if (if3.host_gnt !== 1'b1) begin err_cnt++; $display("FAIL hrd_wr_gnt: got %b want 1", if3.host_gnt); end
      tick(1);
      if3.host_we = 0; if3.sm_gbuf_ren = 1; if3.sm_gbuf_raddr = 12'h020;
      #1;
      vec_cnt++; if (if3.host_gnt !== 1'b0) begin err_cnt++; $display("FAIL hrd_spu_prio: got %b want 0", if3.host_gnt); end
      tick(1);
      if3.sm_gbuf_ren = 0;
      #1;
      vec_cnt++; if (if3.host_gnt !== 1'b1) begin err_cnt++; $display("FAIL hrd_gnt: got %b want 1", if3.host_gnt); end
      tick(1);
      for (int c = 1; c < 3; c++) begin
         #1;
         vec_cnt++; if (if3.host_gnt !== 1'b0) begin err_cnt++; $display("FAIL hrd_wait_gnt[N+%0d]: got %b want 0", c, if3.host_gnt); end
         vec_cnt++; if (if3.host_rvalid !== 1'b0) begin err_cnt++; $display("FAIL hrd_early_vld[N+%0d]: got %b want 0", c, if3.host_rvalid); end
         tick(1);
      end
      #1;
      vec_cnt++; if (if3.host_rvalid !== 1'b1) begin err_cnt++; $display("FAIL hrd_vld: got %b want 1", if3.host_rvalid); end
      vec_cnt++; if (if3.host_rdata !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL hrd_data: got %h want a5a5a5a5", if3.host_rdata); end
      vec_cnt++; if (if3.host_gnt !== 1'b0) begin err_cnt++; $display("FAIL hrd_gnt_at_vld: got %b want 0", if3.host_gnt); end
      tick(1);
      vec_cnt++; if (if3.host_gnt !== 1'b1) begin err_cnt++; $display("FAIL hrd_second_gnt: got %b want 1", if3.host_gnt); end
      vec_cnt++; if (if3.host_rvalid !== 1'b0) begin err_cnt++; $display("FAIL hrd_vld_pulse: got %b want 0", if3.host_rvalid); end
      vec_cnt++; if (if3.host_rdata !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL hrd_data_hold: got %h want a5a5a5a5", if3.host_rdata); end
      vec_cnt++; if (if3.host_stall_cnt !== 16'd4) begin err_cnt++; $display("FAIL hrd_stall: got %0d want 4", if3.host_stall_cnt); end
      tick(1);
      if3.host_req = 0;
      tick(2);
      vec_cnt++; if (if3.host_rvalid !== 1'b1) begin err_cnt++; $display("FAIL hrd_second_vld: got %b want 1", if3.host_rvalid); end
      tick(1);
   endtask

   task automatic test_stall_sat();
      if1.host_req = 1; if1.host_we = 0; if1.host_addr = 12'h030;
      if1.sm_gbuf_ren = 1; if1.sm_gbuf_raddr = 12'h010;
      tick(65531);
      vec_cnt++; if (if1.host_stall_cnt !== 16'hFFFE) begin err_cnt++; $display("FAIL stall_pre_sat: got %h want fffe", if1.host_stall_cnt); end
      tick(1);
      vec_cnt++; if (if1.host_stall_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL stall_sat: got %h want ffff", if1.host_stall_cnt); end
      tick(70000 - 65532);
      vec_cnt++; if (if1.host_stall_cnt !== 16'hFFFF) begin err_cnt++; $display("FAIL stall_no_wrap: got %h want ffff", if1.host_stall_cnt); end
      if1.host_req = 0; if1.sm_gbuf_ren = 0;
      tick(1);
   endtask

   task automatic test_reset_inflight();
      if3.host_req = 1; if3.host_we = 0; if3.host_addr = 12'h030;
      tick(1);
      if3.host_req = 0; if3.sm_gbuf_ren = 1; if3.sm_gbuf_raddr = 12'h020;
      tick(1);
      if3.sm_gbuf_ren = 0;
      rst_n = 0;
      #1;
      vec_cnt++; if (if3.sm_gbuf_rdata !== 32'h0) begin err_cnt++; $display("FAIL rstf_sm_rdata: got %h want 0", if3.sm_gbuf_rdata); end
      vec_cnt++; if (if3.host_rdata !== 32'h0) begin err_cnt++; $display("FAIL rstf_host_rdata: got %h want 0", if3.host_rdata); end
      vec_cnt++; if (if1.host_stall_cnt !== 16'h0) begin err_cnt++; $display("FAIL rstf_stall: got %h want 0", if1.host_stall_cnt); end
      vec_cnt++; if (if1.sm_gbuf_rdata !== 32'h0) begin err_cnt++; $display("FAIL rstf_sm_rdata1: got %h want 0", if1.sm_gbuf_rdata); end
      tick(2);
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         vec_cnt++; if (if3.host_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rstf_no_vld[%0d]: got %b want 0", c, if3.host_rvalid); end
         vec_cnt++; if (if3.sm_gbuf_rdata !== 32'h0) begin err_cnt++; $display("FAIL rstf_no_sm[%0d]: got %h want 0", c, if3.sm_gbuf_rdata); end
         tick(1);
      end
      vec_cnt++; if (if3.host_rdata !== 32'h0) begin err_cnt++; $display("FAIL rstf_hrdata_after: got %h want 0", if3.host_rdata); end
   endtask

   task automatic test_after_reset();
      rst_n = 0;
      tick(1);
      rst_n = 1;
      if1.host_req = 1; if1.host_we = 1; if1.host_addr = 12'h040; if1.host_wdata = 32'hCAFEF00D;
      if3.host_req = 1; if3.host_we = 0; if3.host_addr = 12'h030;
      #1;
      vec_cnt++; if (if1.host_gnt !== 1'b1) begin err_cnt++; $display("FAIL first_wr_gnt: got %b want 1", if1.host_gnt); end
      vec_cnt++; if (if3.host_gnt !== 1'b1) begin err_cnt++; $display("FAIL first_rd_gnt: got %b want 1", if3.host_gnt); end
      tick(1);
      if1.host_req = 0; if1.host_we = 0; if1.sm_gbuf_ren = 1; if1.sm_gbuf_raddr = 12'h040;
      if3.host_req = 0;
      tick(1);
      if1.sm_gbuf_ren = 0;
      #1;
      vec_cnt++; if (if1.sm_gbuf_rdata !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL first_wr_readback: got %h want cafef00d", if1.sm_gbuf_rdata); end
      vec_cnt++; if (if1.host_stall_cnt !== 16'h0) begin err_cnt++; $display("FAIL first_stall: got %h want 0", if1.host_stall_cnt); end
      tick(1);
      vec_cnt++; if (if3.host_rvalid !== 1'b1) begin err_cnt++; $display("FAIL first_rd_vld: got %b want 1", if3.host_rvalid); end
      vec_cnt++; if (if3.host_rdata !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL first_rd_data: got %h want a5a5a5a5", if3.host_rdata); end
      tick(1);
   endtask

   initial begin
      test_reset();
      test_spu_rw();
      test_same_cycle();
      test_host_write_stall();
      test_host_read();
      test_stall_sat();
      test_reset_inflight();
      test_after_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/spu_gbuf_resp.md
SPU_GBUF_RESP -- requirements
Module: spu_gbuf_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, word address width; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 Parameter RLATENCY, default 1, read latency in cycles from ren to rdata; legal range 1..4.
REQ-004 core_clk  input  1  process clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sm_gbuf_ren  input  1  SPU read enable; no backpressure.
REQ-007 sm_gbuf_raddr  input  ADDR_WIDTH  SPU read address, qualified by sm_gbuf_ren.
REQ-008 sm_gbuf_rdata  output  DATA_WIDTH  SPU read data, valid RLATENCY cycles after sm_gbuf_ren.
REQ-009 sm_gbuf_wen  input  1  SPU write enable; no backpressure.
REQ-010 sm_gbuf_waddr  input  ADDR_WIDTH  SPU write address.
REQ-011 sm_gbuf_wdata  input  DATA_WIDTH  SPU write data.
REQ-012 host_req  input  1  host (DMA) access request; held with host_we/addr/wdata stable until host_gnt.
REQ-013 host_we  input  1  1 = host write, 0 = host read.
REQ-014 host_addr  input  ADDR_WIDTH  host address.
REQ-015 host_wdata  input  DATA_WIDTH  host write data.
REQ-016 host_gnt  output  1  one-cycle accept pulse for the current host request.
REQ-017 host_rvalid  output  1  one-cycle pulse, host_rdata valid.
REQ-018 host_rdata  output  DATA_WIDTH  host read data.
REQ-019 host_stall_cnt  output  16  saturating count of cycles host_req was high without grant.

Function
REQ-020 Storage is one 1R1W array of 2**ADDR_WIDTH x DATA_WIDTH; contents are not reset.
REQ-021 SPU accesses have absolute priority; SPU read and SPU write are never delayed or dropped.
REQ-022 Host write is granted (host_gnt=1, array written that cycle) only when host_req=1, host_we=1 and sm_gbuf_wen=0.
REQ-023 Host read is granted only when host_req=1, host_we=0, sm_gbuf_ren=0 and the host FSM is H_IDLE.
REQ-024 Host FSM: H_IDLE -> H_RD_WAIT on host read grant; H_RD_WAIT -> H_IDLE on the cycle host_rvalid is asserted; host writes never leave H_IDLE.
REQ-025 host_rvalid asserts exactly RLATENCY cycles after host read grant, together with host_rdata.
REQ-026 Read port carries a RLATENCY-deep valid/owner pipeline; stage 0 captures array data, remaining stages delay it.
REQ-027 sm_gbuf_rdata updates only when an SPU read completes; otherwise holds its last value.
REQ-028 host_rdata updates only with host_rvalid; otherwise holds.
REQ-029 Read and write to the same address in the same cycle: read returns the new (written) data (write-first).
REQ-030 Write granted in cycle N is visible to any read issued in cycle N or later.
REQ-031 host_stall_cnt increments each cycle host_req=1 and host_gnt=0, saturates at 16'hFFFF, never wraps.
REQ-032 Address arithmetic is unsigned, width ADDR_WIDTH; no bounds check (full range legal).

Reset
REQ-033 On rst_n low: sm_gbuf_rdata=0, host_rdata=0, host_gnt=0, host_rvalid=0, host_stall_cnt=0, host FSM=H_IDLE, all pipeline valids=0.
REQ-034 Reset mid-read discards all in-flight reads; no rvalid or rdata update follows reset release for them.
REQ-035 After reset release the first request is accepted in the first clock edge.

Structure
REQ-036 Host FSM state encodings and RLATENCY legal-range constants belong in the shared spu package.
REQ-037 Array is a separate sub-module spu_gbuf_ram (1R1W, write-first, registered read) so it can be swapped for an SRAM macro.

Verification
REQ-038 RLATENCY=1: SPU write addr 0x010 data 0xDEADBEEF, next cycle SPU read 0x010 -> sm_gbuf_rdata=0xDEADBEEF one cycle later.
REQ-039 Same cycle SPU write 0x020=0x12345678 and SPU read 0x020 -> rdata=0x12345678 after RLATENCY.
REQ-040 Host write 0x030=0xA5A5A5A5 held for 3 cycles while sm_gbuf_wen=1 -> host_gnt on 4th cycle, host_stall_cnt=3.
REQ-041 RLATENCY=3: host read 0x030 granted cycle N -> host_rvalid=1, host_rdata=0xA5A5A5A5 at N+3; second host read not granted before N+3.
REQ-042 Hold host_req with sm_gbuf_ren=1 for 70000 cycles -> host_stall_cnt=16'hFFFF, no wrap.
REQ-043 Assert rst_n low with 2 reads in flight -> no host_rvalid after release, all outputs 0.
